laser_tx_serializer: RTL and testbench

LASER_TX_SERIALIZER -- requirements
Module: laser_tx_serializer

---
 rtl/laser_pkg.sv | 24 ++
 rtl/bit_timer.sv | 34 +++
 rtl/laser_tx_serializer.sv | 139 +++++++++++++
 tb/tb_laser_tx_serializer.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/laser_pkg.sv
// laser_pkg: frame state type and line levels shared by the laser transmit and receive sides.
// Optional build macro: LASER_TX_PARITY_EN adds the PARITY state.
// Revision: 1.0
`default_nettype none

package laser_pkg;

  localparam logic LASER_IDLE_LEVEL  = 1'b0;
  localparam logic LASER_START_LEVEL = 1'b1;
  localparam logic LASER_STOP_LEVEL  = 1'b0;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
`ifdef LASER_TX_PARITY_EN
    ST_PARITY = 3'd4,
`endif
    ST_STOP   = 3'd3
  } tx_state_t;

endpackage

`default_nettype wire

// File: rtl/bit_timer.sv
// bit_timer: counts clock cycles within one bit time; tick marks the last cycle of the bit.
// Revision: 1.0
`default_nettype none

module bit_timer #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clock,
  input  logic reset_n,
  input  logic start,
  output logic tick
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] r_cnt;

  // Reloads on a new frame and at every bit boundary, so it never runs past LAST_CNT.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt <= '0;
    end else if (start || (r_cnt == LAST_CNT)) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign tick = (r_cnt == LAST_CNT);

endmodule

`default_nettype wire

// File: rtl/laser_tx_serializer.sv
// laser_tx_serializer: frames a payload word as START, DATA (LSB first), optional PARITY, STOP on laser_out.
// Optional build macro: LASER_TX_PARITY_EN enables an even-parity bit. Revision: 1.0
`default_nettype none

module laser_tx_serializer #(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_W       = 8
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic [DATA_W-1:0] data_in,
  input  logic              data_valid,
  output logic              data_ready,
  output logic              laser_out,
  output logic              busy
);

  import laser_pkg::*;

  localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_W - 1);

  tx_state_t         r_state;
  logic [DATA_W-1:0] r_word;
  logic [IDX_W-1:0]  r_bit_idx;
  logic              r_laser;
  logic              r_ready;
  logic              r_busy;
`ifdef LASER_TX_PARITY_EN
  logic              r_parity;
`endif

  logic              w_xfer;
  logic              w_tick;
  logic [IDX_W-1:0]  w_next_idx;

  // r_ready is only ever high in IDLE, so this also implies the IDLE state.
  assign w_xfer     = data_valid && r_ready;
  assign w_next_idx = r_bit_idx + 1'b1;

  bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_bit_timer (
    .clock  (clock),
    .reset_n(reset_n),
    .start  (w_xfer),
    .tick   (w_tick)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= ST_IDLE;
      r_word    <= '0;
      r_bit_idx <= '0;
      r_laser   <= LASER_IDLE_LEVEL;
      r_ready   <= 1'b0;
      r_busy    <= 1'b0;
`ifdef LASER_TX_PARITY_EN
      r_parity  <= 1'b0;
`endif
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_bit_idx <= '0;
          if (w_xfer) begin
            r_state  <= ST_START;
            r_word   <= data_in;
`ifdef LASER_TX_PARITY_EN
            r_parity <= ^data_in;
`endif
            r_laser  <= LASER_START_LEVEL;
            r_ready  <= 1'b0;
            r_busy   <= 1'b1;
          end else begin
            r_laser  <= LASER_IDLE_LEVEL;
            r_ready  <= 1'b1;
            r_busy   <= 1'b0;
          end
        end

        ST_START: begin
          if (w_tick) begin
            r_state <= ST_DATA;
            r_laser <= r_word[0];
          end
        end

        ST_DATA: begin
          if (w_tick) begin
            if (r_bit_idx == LAST_IDX) begin
`ifdef LASER_TX_PARITY_EN
              r_state <= ST_PARITY;
              r_laser <= r_parity;
`else
              r_state <= ST_STOP;
              r_laser <= LASER_STOP_LEVEL;
`endif
            end else begin
              r_bit_idx <= w_next_idx;
              r_laser   <= r_word[w_next_idx];
            end
          end
        end

`ifdef LASER_TX_PARITY_EN
        ST_PARITY: begin
          if (w_tick) begin
            r_state <= ST_STOP;
            r_laser <= LASER_STOP_LEVEL;
          end
        end
`endif

        ST_STOP: begin
          if (w_tick) begin
            r_state <= ST_IDLE;
            r_laser <= LASER_IDLE_LEVEL;
            r_ready <= 1'b1;
            r_busy  <= 1'b0;
          end
        end

        default: begin
          r_state <= ST_IDLE;
          r_laser <= LASER_IDLE_LEVEL;
          r_ready <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign data_ready = r_ready;
  assign laser_out  = r_laser;
  assign busy       = r_busy;

endmodule

`default_nettype wire

// File: tb/tb_laser_tx_serializer.sv
// tb_laser_tx_serializer: self-checking bench for laser_tx_serializer (CLKS_PER_BIT=4, DATA_W=8).
// Honours LASER_TX_PARITY_EN for the expected frame layout. Revision: 1.0
`default_nettype none

module tb_laser_tx_serializer;

  localparam int CPB = 4;
  localparam int DW  = 8;
`ifdef LASER_TX_PARITY_EN
  localparam int FB  = DW + 3;
`else
  localparam int FB  = DW + 2;
`endif
  localparam int FL  = FB * CPB;

  logic          clock      = 1'b0;
  logic          reset_n    = 1'b1;
  logic [DW-1:0] data_in    = '0;
  logic          data_valid = 1'b0;
  logic          data_ready;
  logic          laser_out;
  logic          busy;

  int errors = 0;
  int checks = 0;

  always #5 clock = ~clock;

  laser_tx_serializer #(
    .CLKS_PER_BIT(CPB),
    .DATA_W      (DW)
  ) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .data_in   (data_in),
    .data_valid(data_valid),
    .data_ready(data_ready),
    .laser_out (laser_out),
    .busy      (busy)
  );

  // Reference: level of cycle k (0 = first cycle after the transfer edge) of a frame carrying w.
  function automatic logic exp_bit(input logic [DW-1:0] w, input int k);
    int b;
    b = k / CPB;
    if (b == 0) return 1'b1;
    if (b <= DW) return w[b-1];
`ifdef LASER_TX_PARITY_EN
    if (b == DW + 1) return ^w;
`endif
    return 1'b0;
  endfunction

  task automatic wait_ready(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clock);
      if (data_ready === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset;
    #1 reset_n = 1'b0;
    data_valid = 1'b0;
    #2;
    checks++;
    if ({laser_out, busy, data_ready} !== 3'b000) begin
      errors++;
      $display("FAIL reset_held: {laser,busy,ready}=%b expected 000", {laser_out, busy, data_ready});
    end
    @(negedge clock);
    reset_n = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clock);
      checks++;
      if ({laser_out, busy, data_ready} !== 3'b001) begin
        errors++;
        $display("FAIL reset_idle cycle %0d: {laser,busy,ready}=%b expected 001", i, {laser_out, busy, data_ready});
      end
    end
  endtask

  task automatic test_single_frame;
    bit ok;
    logic [FB-1:0] pat;
`ifdef LASER_TX_PARITY_EN
    pat = 11'b00101001011;
`else
    pat = 10'b0101001011;
`endif
    wait_ready(ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL single_wait_ready: data_ready=%b expected 1", data_ready);
    end
    data_in    = 8'hA5;
    data_valid = 1'b1;
    for (int k = 0; k < FL; k++) begin
      @(negedge clock);
      data_valid = 1'b0;
      checks++;
      if ({laser_out, busy, data_ready} !== {pat[k/CPB], 2'b10}) begin
        errors++;
        $display("FAIL single_A5 k=%0d: {laser,busy,ready}=%b expected %b", k, {laser_out, busy, data_ready}, {pat[k/CPB], 2'b10});
      end
    end
    @(negedge clock);
    checks++;
    if ({laser_out, busy, data_ready} !== 3'b001) begin
      errors++;
      $display("FAIL single_ready_return: {laser,busy,ready}=%b expected 001", {laser_out, busy, data_ready});
    end
  endtask

  task automatic test_back_to_back;
    bit ok;
    logic [DW-1:0] words [2];
    words[0] = 8'h00;
    words[1] = 8'hFF;
    wait_ready(ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL stream_wait_ready: data_ready=%b expected 1", data_ready);
    end
    data_in    = words[0];
    data_valid = 1'b1;
    for (int f = 0; f < 2; f++) begin
      for (int k = 0; k < FL; k++) begin
        @(negedge clock);
        if (k == 0) begin
          if (f == 0) data_in = words[1];
          else data_valid = 1'b0;
        end
        checks++;
        if ({laser_out, busy, data_ready} !== {exp_bit(words[f], k), 2'b10}) begin
          errors++;
          $display("FAIL stream f=%0d k=%0d: {laser,busy,ready}=%b expected %b", f, k, {laser_out, busy, data_ready}, {exp_bit(words[f], k), 2'b10});
        end
      end
      @(negedge clock);
      checks++;
      if ({laser_out, busy, data_ready} !== 3'b001) begin
        errors++;
        $display("FAIL stream_gap f=%0d: {laser,busy,ready}=%b expected 001", f, {laser_out, busy, data_ready});
      end
    end
  endtask

  task automatic test_ignored_input;
    bit ok;
    wait_ready(ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL ignore_wait_ready: data_ready=%b expected 1", data_ready);
    end
    data_in    = 8'h3C;
    data_valid = 1'b1;
    for (int k = 0; k < FL; k++) begin
      @(negedge clock);
      data_in    = DW'($urandom);
      data_valid = 1'($urandom);
      checks++;
      if (laser_out !== exp_bit(8'h3C, k)) begin
        errors++;
        $display("FAIL ignore_3C k=%0d: laser_out=%b expected %b", k, laser_out, exp_bit(8'h3C, k));
      end
    end
    @(negedge clock);
    data_valid = 1'b0;
    checks++;
    if ({laser_out, busy, data_ready} !== 3'b001) begin
      errors++;
      $display("FAIL ignore_end: {laser,busy,ready}=%b expected 001", {laser_out, busy, data_ready});
    end
  endtask

  task automatic test_random_words;
    bit ok;
    logic [DW-1:0] w;
    for (int n = 0; n < 3; n++) begin
      w = DW'($urandom);
      wait_ready(ok);
      checks++;
      if (!ok) begin
        errors++;
        $display("FAIL rand_wait_ready n=%0d: data_ready=%b expected 1", n, data_ready);
      end
      data_in    = w;
      data_valid = 1'b1;
      for (int k = 0; k < FL; k++) begin
        @(negedge clock);
        data_valid = 1'b0;
        checks++;
        if (laser_out !== exp_bit(w, k)) begin
          errors++;
          $display("FAIL rand word=%h k=%0d: laser_out=%b expected %b", w, k, laser_out, exp_bit(w, k));
        end
      end
    end
  endtask

  task automatic test_midframe_reset;
    bit ok;
    wait_ready(ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL midrst_wait_ready: data_ready=%b expected 1", data_ready);
    end
    data_in    = 8'h0F;
    data_valid = 1'b1;
    // Cycle 17 lies inside DATA bit 3, which is 1 for 0x0F.
    for (int k = 0; k <= 17; k++) begin
      @(negedge clock);
      data_valid = 1'b0;
      checks++;
      if (laser_out !== exp_bit(8'h0F, k)) begin
        errors++;
        $display("FAIL midrst_pre k=%0d: laser_out=%b expected %b", k, laser_out, exp_bit(8'h0F, k));
      end
    end
    #1 reset_n = 1'b0;
    #1;
    checks++;
    if ({laser_out, busy, data_ready} !== 3'b000) begin
      errors++;
      $display("FAIL midrst_async: {laser,busy,ready}=%b expected 000", {laser_out, busy, data_ready});
    end
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    checks++;
    if ({laser_out, busy, data_ready} !== 3'b001) begin
      errors++;
      $display("FAIL midrst_release: {laser,busy,ready}=%b expected 001", {laser_out, busy, data_ready});
    end
    data_in    = 8'hC3;
    data_valid = 1'b1;
    for (int k = 0; k < FL; k++) begin
      @(negedge clock);
      data_valid = 1'b0;
      checks++;
      if (laser_out !== exp_bit(8'hC3, k)) begin
        errors++;
        $display("FAIL midrst_after k=%0d: laser_out=%b expected %b", k, laser_out, exp_bit(8'hC3, k));
      end
    end
    @(negedge clock);
    checks++;
    if ({laser_out, busy, data_ready} !== 3'b001) begin
      errors++;
      $display("FAIL midrst_after_end: {laser,busy,ready}=%b expected 001", {laser_out, busy, data_ready});
    end
  endtask

`ifdef LASER_TX_PARITY_EN
  task automatic test_parity;
    bit ok;
    logic [DW-1:0] words [2];
    logic          par   [2];
    words[0] = 8'h01; par[0] = 1'b1;
    words[1] = 8'hA5; par[1] = 1'b0;
    for (int f = 0; f < 2; f++) begin
      wait_ready(ok);
      checks++;
      if (!ok) begin
        errors++;
        $display("FAIL parity_wait_ready f=%0d: data_ready=%b expected 1", f, data_ready);
      end
      data_in    = words[f];
      data_valid = 1'b1;
      for (int k = 0; k < 44; k++) begin
        @(negedge clock);
        data_valid = 1'b0;
        checks++;
        if ((k / CPB) == DW + 1) begin
          if (laser_out !== par[f]) begin
            errors++;
            $display("FAIL parity_bit word=%h k=%0d: laser_out=%b expected %b", words[f], k, laser_out, par[f]);
          end
        end else if (laser_out !== exp_bit(words[f], k)) begin
          errors++;
          $display("FAIL parity_frame word=%h k=%0d: laser_out=%b expected %b", words[f], k, laser_out, exp_bit(words[f], k));
        end
      end
      @(negedge clock);
      checks++;
      if ({laser_out, busy, data_ready} !== 3'b001) begin
        errors++;
        $display("FAIL parity_len word=%h: {laser,busy,ready}=%b expected 001", words[f], {laser_out, busy, data_ready});
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_ignored_input();
    test_random_words();
    test_midframe_reset();
`ifdef LASER_TX_PARITY_EN
    test_parity();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors + 1);
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
